sd_result_logger: RTL and testbench

- Controller that sequences the sdspihost block to log UUT results to the SD card in raw sectors.
- Arbitrates between two UUT byte-result sources (round-robin), buffers each in its own FIFO, and packs them into 2-byte records.
- Writes records as consecutive 512-byte blocks starting at a fixed sector.
- Sits between the UUT result ports and the sdspihost write interface, replacing hand-sequenced writes in the autotest FSM.

---
 rtl/sd_result_logger_if.sv | 19 +
 rtl/sd_result_logger.sv | 113 +++++++++++
 tb/tb_sd_result_logger.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sd_result_logger_if.sv
// sd_result_logger_if: write-side handshake between the result logger and the sdspihost block
interface sd_result_logger_if;
    logic        spi_busy;
    logic        spi_err;
    logic        spi_crc_err;
    logic        spi_rst;
    logic        spi_w_block;
    logic        spi_w_byte;
    logic [31:0] spi_block_addr;
    logic [7:0]  spi_data_in;
    modport master (
        input  spi_busy, spi_err, spi_crc_err,
        output spi_rst, spi_w_block, spi_w_byte, spi_block_addr, spi_data_in
    );
    modport slave (
        output spi_busy, spi_err, spi_crc_err,
        input  spi_rst, spi_w_block, spi_w_byte, spi_block_addr, spi_data_in
    );
endinterface

// File: rtl/sd_result_logger.sv
// sd_result_logger: round-robin logs two UUT byte streams as tagged 2-byte records into raw SD blocks
module sd_result_logger #(
    parameter logic [31:0] BASE_BLOCK = 32'd4096,
    parameter logic [15:0] MAX_BLOCKS = 16'd1024,
    parameter int          FIFO_DEPTH = 16,
    parameter int          RST_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      flush,
    input  logic [7:0]                src1_data,
    input  logic                      src1_valid,
    input  logic [7:0]                src2_data,
    input  logic                      src2_valid,
    sd_result_logger_if.master        host,
    output logic                      done,
    output logic                      error,
    output logic                      overflow,
    output logic [15:0]               blocks_written
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [3:0] {
        IDLE, HOST_RST, WAIT_READY, WAIT_DATA, CMD, ACK, BYTE, BYTE_WAIT, COMMIT, DONE, ERROR
    } state_t;
    state_t state, state_n;
    logic [7:0] rst_cnt;
    logic [8:0] byte_cnt;
    logic seen, flush_l, ptr, cur_src, sel, cap, mid, have, grant, hs_done;
    logic [1:0] empty, full, push, pop, vld;
    logic [1:0][7:0] din, head;
    logic [15:0] bw_inc;
    assign vld = {src2_valid, src1_valid};
    assign din = {src2_data, src1_data};
    assign cap = !(state inside {IDLE, HOST_RST, DONE, ERROR});
    assign mid = state inside {CMD, ACK, BYTE, BYTE_WAIT, COMMIT};
    assign have = empty != 2'b11;
    // ptr names the preferred source; it only decides when both FIFOs hold data
    assign sel = !empty[0] && !empty[1] ? ptr : empty[0];
    assign grant = state == BYTE && !byte_cnt[0] && !flush_l;
    assign hs_done = seen && !host.spi_busy;
    assign bw_inc = blocks_written + 16'(blocks_written != MAX_BLOCKS);
    for (genvar i = 0; i < 2; i++) begin : g_fifo
        logic [7:0] mem [FIFO_DEPTH];
        logic [AW:0] wp, rp;
        assign empty[i] = wp == rp;
        assign full[i] = wp == {~rp[AW], rp[AW-1:0]};
        assign head[i] = mem[rp[AW-1:0]];
        assign pop[i] = state == BYTE && byte_cnt[0] && !flush_l && cur_src == 1'(i);
        assign push[i] = cap && vld[i] && (!full[i] || pop[i]);
        always_ff @(posedge clk) begin
            if (push[i]) mem[wp[AW-1:0]] <= din[i];
            if (!rst || start) begin
                wp <= '0;
                rp <= '0;
            end else begin
                wp <= wp + (AW+1)'(push[i]);
                rp <= rp + (AW+1)'(pop[i]);
            end
        end
    end
    always_ff @(posedge clk) state <= !rst ? IDLE : state_n;
    always_comb begin
        state_n = state;
        if (start) state_n = HOST_RST;
        else if ((host.spi_err || host.spi_crc_err) && !(state inside {IDLE, DONE})) state_n = ERROR;
        else
            case (state)
                HOST_RST:   if (rst_cnt == 8'(RST_CYCLES - 1)) state_n = WAIT_READY;
                WAIT_READY: if (!host.spi_busy) state_n = WAIT_DATA;
                WAIT_DATA:  if (have) state_n = CMD; else if (flush) state_n = DONE;
                CMD:        state_n = ACK;
                ACK:        if (hs_done) state_n = BYTE;
                BYTE:       state_n = BYTE_WAIT;
                BYTE_WAIT:  if (hs_done && byte_cnt == 9'd511) state_n = COMMIT;
                            else if (hs_done && (!byte_cnt[0] || have || flush_l)) state_n = BYTE;
                COMMIT:     if (!host.spi_busy) state_n = flush_l || flush || bw_inc == MAX_BLOCKS ? DONE : WAIT_DATA;
                default:    state_n = state;
            endcase
    end
    always_ff @(posedge clk) begin
        if (!rst || start) begin
            rst_cnt <= '0;
            byte_cnt <= '0;
            seen <= 1'b0;
            flush_l <= 1'b0;
            ptr <= 1'b0;
            cur_src <= 1'b0;
            overflow <= 1'b0;
            blocks_written <= '0;
        end else begin
            rst_cnt <= state == HOST_RST ? rst_cnt + 8'd1 : '0;
            byte_cnt <= state == CMD ? '0 : byte_cnt + 9'(state == BYTE_WAIT && state_n == BYTE);
            seen <= state_n == state && (seen || host.spi_busy);
            flush_l <= state_n inside {DONE, ERROR} ? 1'b0 : flush_l || (flush && mid);
            if (grant) begin
                cur_src <= sel;
                ptr <= !sel;
            end
            overflow <= overflow || |(vld & full & ~pop & {2{cap}});
            if (state == COMMIT && !host.spi_busy) blocks_written <= bw_inc;
        end
    end
    always_comb begin
        host.spi_rst = state inside {IDLE, HOST_RST};
        host.spi_w_block = state == CMD;
        host.spi_w_byte = state == BYTE;
        host.spi_data_in = state != BYTE || flush_l ? 8'h00 : byte_cnt[0] ? head[cur_src] : sel ? 8'hA2 : 8'hA1;
        done = state == DONE;
        error = state == ERROR;
    end
    assign host.spi_block_addr = BASE_BLOCK + {16'd0, blocks_written};
endmodule

// File: tb/tb_sd_result_logger.sv
// tb_sd_result_logger: randomized bench with an SD host model and a record-level reference model
module tb_sd_result_logger;
    localparam logic [31:0] BASE = 32'd4096;
    localparam int DEPTH = 16;
    logic clk = 0, rst = 0, start = 0, flush = 0;
    logic [7:0] src1_data = 0, src2_data = 0;
    logic src1_valid = 0, src2_valid = 0;
    logic done, error, overflow;
    logic [15:0] blocks_written;
    int checks = 0, failures = 0;
    int busy_cnt = 0;
    sd_result_logger_if ifc();
    sd_result_logger #(.MAX_BLOCKS(16'd2)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .src1_data(src1_data), .src1_valid(src1_valid),
        .src2_data(src2_data), .src2_valid(src2_valid),
        .host(ifc.master),
        .done(done), .error(error), .overflow(overflow), .blocks_written(blocks_written)
    );
    always #5 clk = ~clk;
    // host: busy through reset and 20 cycles of init, then 1-3 busy cycles per command or byte
    always @(posedge clk)
        if (!rst || ifc.spi_rst) busy_cnt <= 20;
        else if (ifc.spi_w_block || ifc.spi_w_byte) busy_cnt <= 1 + int'($urandom_range(2));
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    assign ifc.spi_busy = busy_cnt != 0;
    assign ifc.spi_err = 1'b0;
    initial ifc.spi_crc_err = 1'b0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // reference: per-source queues, last-served arbitration, 512-byte blocks
    logic [7:0] q1[$], q2[$];
    int idx = 0, committed = 0, last = 2, cur = 1, wblk = 0, ovf_m = 0;
    logic zero_mode = 0, cap_on = 0;
    always @(negedge clk) begin
        if (!rst || start) begin
            q1.delete();
            q2.delete();
            idx = 0; committed = 0; last = 2; wblk = 0; ovf_m = 0;
        end else begin
            if (ifc.spi_w_block) begin
                check("addr", ifc.spi_block_addr, BASE + 32'(committed));
                idx = 0;
                wblk++;
            end
            if (ifc.spi_w_byte) begin
                if (zero_mode) check("pad", ifc.spi_data_in, 0);
                else if (idx % 2 == 0) begin
                    cur = (q1.size() > 0 && q2.size() > 0) ? 3 - last : (q1.size() > 0 ? 1 : 2);
                    check("tag", ifc.spi_data_in, cur == 1 ? 8'hA1 : 8'hA2);
                    last = cur;
                end else if (cur == 1 && q1.size() > 0) check("data1", ifc.spi_data_in, q1.pop_front());
                else if (cur == 2 && q2.size() > 0) check("data2", ifc.spi_data_in, q2.pop_front());
                else check("data_none", 1, 0);
                idx++;
                if (idx == 512) committed++;
            end
            if (cap_on && src1_valid) begin
                if (q1.size() < DEPTH) q1.push_back(src1_data); else ovf_m = 1;
            end
            if (cap_on && src2_valid) begin
                if (q2.size() < DEPTH) q2.push_back(src2_data); else ovf_m = 1;
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_start();
        zero_mode = 0; cap_on = 0; src1_valid = 0; src2_valid = 0;
        start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 200 && ifc.spi_rst; i++) tick();
        check("init_rst_low", ifc.spi_rst, 0);
        cap_on = 1;
    endtask
    task automatic push(input int s, input logic [7:0] d);
        for (int i = 0; i < 2000 && (s == 1 ? q1.size() : q2.size()) >= DEPTH; i++) tick();
        if (s == 1) begin src1_valid = 1; src1_data = d; end
        else begin src2_valid = 1; src2_data = d; end
        tick();
        src1_valid = 0; src2_valid = 0;
    endtask
    task automatic wait_idx(input int n);
        for (int i = 0; i < 20000 && idx < n; i++) tick();
        check("reach_byte", 32'(idx >= n), 1);
    endtask
    task automatic wait_committed(input int n);
        for (int i = 0; i < 30000 && committed < n; i++) tick();
        check("reach_commit", 32'(committed), 32'(n));
    endtask
    task automatic wait_done();
        for (int i = 0; i < 30000 && !done; i++) tick();
        check("done", done, 1);
    endtask
    task automatic check_reset(input string tag);
        check({tag, "_spi_rst"}, ifc.spi_rst, 1);
        check({tag, "_w_block"}, ifc.spi_w_block, 0);
        check({tag, "_w_byte"}, ifc.spi_w_byte, 0);
        check({tag, "_data"}, ifc.spi_data_in, 0);
        check({tag, "_addr"}, ifc.spi_block_addr, BASE);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_bw"}, blocks_written, 0);
    endtask
    initial begin
        int n;
        repeat (3) tick();
        check_reset("reset");
        rst = 1;
        tick();
        do_start();
        for (int b = 0; b < 256; b++) push(1, 8'(b));
        wait_committed(1);
        for (int i = 0; i < 100 && blocks_written != 1; i++) tick();
        check("basic_bw", blocks_written, 1);
        check("basic_addr", ifc.spi_block_addr, BASE + 1);
        check("basic_ovf", overflow, 0);
        check("basic_wblk", 32'(wblk), 1);
        do_start();
        src1_data = 8'h11; src2_data = 8'h22; src1_valid = 1; src2_valid = 1;
        wait_committed(1);
        src1_valid = 0; src2_valid = 0;
        check("cont_ovf", overflow, 1);
        check("cont_ovf_model", overflow, 32'(ovf_m));
        do_start();
        for (int i = 0; i < 30000 && committed < 1; i++) begin
            src1_valid = $urandom_range(15) == 0; src1_data = 8'($urandom);
            src2_valid = $urandom_range(15) == 0; src2_data = 8'($urandom);
            tick();
        end
        src1_valid = 0; src2_valid = 0;
        check("rand_commit", 32'(committed), 1);
        check("rand_ovf", overflow, 32'(ovf_m));
        do_start();
        for (int b = 0; b < 3; b++) push(2, 8'hB0 + 8'(b));
        wait_idx(6);
        flush = 1; zero_mode = 1;
        tick();
        flush = 0;
        wait_done();
        check("flush_bw", blocks_written, 1);
        check("flush_commit", 32'(committed), 1);
        do_start();
        for (int r = 0; r < 600 && committed < 2; r++) push(1 + int'($urandom_range(1)), 8'($urandom));
        wait_done();
        check("multi_bw", blocks_written, 2);
        check("multi_addr", ifc.spi_block_addr, BASE + 2);
        repeat (50) tick();
        check("multi_wblk", 32'(wblk), 2);
        check("multi_done_hold", done, 1);
        do_start();
        for (int b = 0; b < 50; b++) push(1, 8'(b));
        wait_idx(100);
        ifc.spi_crc_err = 1;
        tick();
        ifc.spi_crc_err = 0;
        check("err_flag", error, 1);
        check("err_bw", blocks_written, 0);
        check("err_w_byte", ifc.spi_w_byte, 0);
        repeat (5) tick();
        check("err_sticky", error, 1);
        cap_on = 0;
        start = 1;
        tick();
        start = 0;
        check("err_cleared", error, 0);
        n = 0;
        while (ifc.spi_rst && n < 50) begin
            n++;
            tick();
        end
        check("err_rst_len", 32'(n), 8);
        do_start();
        for (int b = 0; b < 150; b++) push(1, 8'(b));
        wait_idx(300);
        rst = 0;
        tick();
        check_reset("midrst");
        rst = 1;
        tick();
        do_start();
        repeat (80) tick();
        check("midrst_fifo_empty", 32'(wblk), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
